// File: rtl/dpram_port_master.sv
// -----------------------------------------------------------------------------
// dpram_port_master
//
// Initiator-side controller for a single-clock true dual-port RAM. It turns two
// independent valid/ready request streams (A and B) into per-port RAM
// addr/data/we signals, and returns read data with a one-cycle-late valid
// strobe. After reset it clears every RAM word to INIT_VAL, writing two words
// per cycle. While clearing, no request is accepted. Same-address conflicts are
// resolved with round-robin priority.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_{a,b}_valid/ready     request handshake (accepted when valid & ready)
//   req_{a,b}_we/addr/wdata   request fields (we = 1 write, 0 read)
//   rsp_{a,b}_valid/data      read response (data = RAM q, pass-through)
//   ram_{addr,data,we}_{a,b}  drive to the RAM ports
//   ram_q_{a,b}               registered read data from the RAM ports
//   init_done                 clear finished, requests may be accepted
//   conflict_cnt              saturating count of arbitrated conflicts
// -----------------------------------------------------------------------------
module dpram_port_master #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 6,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req_a_valid,
  output logic              req_a_ready,
  input  logic              req_a_we,
  input  logic [ADDR_W-1:0] req_a_addr,
  input  logic [DATA_W-1:0] req_a_wdata,
  output logic              rsp_a_valid,
  output logic [DATA_W-1:0] rsp_a_data,

  input  logic              req_b_valid,
  output logic              req_b_ready,
  input  logic              req_b_we,
  input  logic [ADDR_W-1:0] req_b_addr,
  input  logic [DATA_W-1:0] req_b_wdata,
  output logic              rsp_b_valid,
  output logic [DATA_W-1:0] rsp_b_data,

  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              ram_we_a,
  input  logic [DATA_W-1:0] ram_q_a,

  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_data_b,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_q_b,

  output logic              init_done,
  output logic [15:0]       conflict_cnt
);

  // The clear walks word pairs, so the counter needs ADDR_W-1 bits. Keep at
  // least one bit so ADDR_W = 1 (a single pair) still elaborates.
  localparam int               CLR_W    = (ADDR_W > 1) ? ADDR_W - 1 : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'((1 << (ADDR_W - 1)) - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CLR_W-1:0] clr_q, clr_d;
  logic             prio_q, prio_d;        // 0 = A wins next conflict, 1 = B
  logic [15:0]      cnt_q, cnt_d;
  logic             rsp_a_valid_q, rsp_a_valid_d;
  logic             rsp_b_valid_q, rsp_b_valid_d;

  logic              in_run;
  logic              conflict;
  logic              acc_a, acc_b;
  logic [ADDR_W-1:0] clr_addr_even;
  logic [ADDR_W-1:0] clr_addr_odd;

  assign in_run = (state_q == ST_RUN);

  // A conflict needs both ports on the same word with at least one writer.
  // Two reads of the same word are harmless and both go through.
  assign conflict = in_run && req_a_valid && req_b_valid &&
                    (req_a_addr == req_b_addr) && (req_a_we || req_b_we);

  assign req_a_ready = in_run && (!conflict || !prio_q);
  assign req_b_ready = in_run && (!conflict ||  prio_q);

  assign acc_a = req_a_valid && req_a_ready;
  assign acc_b = req_b_valid && req_b_ready;

  // Port A clears the even word of each pair, port B the odd word.
  assign clr_addr_even = ADDR_W'({clr_q, 1'b0});
  assign clr_addr_odd  = clr_addr_even | ADDR_W'(1);

  always_comb begin
    if (in_run) begin
      // Address/data follow the request even when not accepted. Only the
      // write enable is gated, so a stalled port cannot disturb the RAM.
      ram_addr_a = req_a_addr;
      ram_data_a = req_a_wdata;
      ram_we_a   = acc_a && req_a_we;
      ram_addr_b = req_b_addr;
      ram_data_b = req_b_wdata;
      ram_we_b   = acc_b && req_b_we;
    end else begin
      ram_addr_a = clr_addr_even;
      ram_data_a = INIT_VAL;
      ram_we_a   = 1'b1;
      ram_addr_b = clr_addr_odd;
      ram_data_b = INIT_VAL;
      ram_we_b   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;

    if (!in_run) begin
      clr_d = clr_q + CLR_W'(1);
      if (clr_q == CLR_LAST) begin
        state_d = ST_RUN;
      end
    end

    // The loser of this conflict becomes the favourite for the next one,
    // so a held request is guaranteed to win the following conflict.
    if (conflict) begin
      prio_d = ~prio_q;
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    rsp_a_valid_d = acc_a && !req_a_we;
    rsp_b_valid_d = acc_b && !req_b_we;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INIT;
      clr_q         <= '0;
      prio_q        <= 1'b0;
      cnt_q         <= '0;
      rsp_a_valid_q <= 1'b0;
      rsp_b_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_q         <= clr_d;
      prio_q        <= prio_d;
      cnt_q         <= cnt_d;
      rsp_a_valid_q <= rsp_a_valid_d;
      rsp_b_valid_q <= rsp_b_valid_d;
    end
  end

  assign init_done    = in_run;
  assign conflict_cnt = cnt_q;
  assign rsp_a_valid  = rsp_a_valid_q;
  assign rsp_b_valid  = rsp_b_valid_q;
  // The RAM read is registered, so q lines up with the response valid flop.
  assign rsp_a_data   = ram_q_a;
  assign rsp_b_data   = ram_q_b;

endmodule

// File: tb/tb_dpram_port_master.sv
// -----------------------------------------------------------------------------
// tb_dpram_port_master
//
// Bench for dpram_port_master. It contains a behavioural dual-port RAM with a
// registered read, directed scenarios with literal expectations, and a
// randomized phase. A per-cycle compare process on the falling clock edge
// checks every DUT output against a behavioural model of the controller.
// -----------------------------------------------------------------------------
module tb_dpram_port_master;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int HALF  = 32;
  localparam logic [DW-1:0] IVAL = 8'h00;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_a_valid = 1'b0, req_a_we = 1'b0;
  logic [AW-1:0] req_a_addr = '0;
  logic [DW-1:0] req_a_wdata = '0;
  logic          req_b_valid = 1'b0, req_b_we = 1'b0;
  logic [AW-1:0] req_b_addr = '0;
  logic [DW-1:0] req_b_wdata = '0;
  logic          req_a_ready, req_b_ready, rsp_a_valid, rsp_b_valid;
  logic [DW-1:0] rsp_a_data, rsp_b_data;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_data_a, ram_data_b, ram_q_a, ram_q_b;
  logic          ram_we_a, ram_we_b, init_done;
  logic [15:0]   conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dpram_port_master #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(IVAL)) dut (
    .clk(clk), .rst(rst),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready), .req_a_we(req_a_we),
    .req_a_addr(req_a_addr), .req_a_wdata(req_a_wdata),
    .rsp_a_valid(rsp_a_valid), .rsp_a_data(rsp_a_data),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_we(req_b_we),
    .req_b_addr(req_b_addr), .req_b_wdata(req_b_wdata),
    .rsp_b_valid(rsp_b_valid), .rsp_b_data(rsp_b_data),
    .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_we_a(ram_we_a), .ram_q_a(ram_q_a),
    .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b), .ram_we_b(ram_we_b), .ram_q_b(ram_q_b),
    .init_done(init_done), .conflict_cnt(conflict_cnt)
  );

  // Behavioural RAM. It is seeded with non-zero junk so that a missing clear shows.
  logic [DW-1:0] ram [DEPTH];
  bit seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'(i * 7 + 3);
      seeded <= 1'b1;
    end else begin
      if (ram_we_a) ram[ram_addr_a] <= ram_data_a;
      if (ram_we_b) ram[ram_addr_b] <= ram_data_b;
    end
    ram_q_a <= ram[ram_addr_a];
    ram_q_b <= ram[ram_addr_b];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: clear progress, logical memory, round-robin favourite,
  // conflict count and the response due next cycle.
  // ---------------------------------------------------------------------------
  int            m_k, m_cnt;
  bit            m_done, m_prio, m_pa, m_pb;
  logic [DW-1:0] m_da, m_db;
  logic [DW-1:0] m_mem [DEPTH];

  always @(negedge clk) begin : cmp_proc
    bit conf, ra, rb, acc_a, acc_b;
    if (rst) begin
      m_k = 0; m_cnt = 0; m_done = 0; m_prio = 0; m_pa = 0; m_pb = 0;
    end
    chk("init_done", 32'(init_done), 32'(m_done));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    chk("rsp_a_valid", 32'(rsp_a_valid), 32'(m_pa));
    chk("rsp_b_valid", 32'(rsp_b_valid), 32'(m_pb));
    if (m_pa) chk("rsp_a_data", 32'(rsp_a_data), 32'(m_da));
    if (m_pb) chk("rsp_b_data", 32'(rsp_b_data), 32'(m_db));
    if (!m_done) begin
      chk("init_ready_a", 32'(req_a_ready), 32'(0));
      chk("init_ready_b", 32'(req_b_ready), 32'(0));
      chk("init_we_a", 32'(ram_we_a), 32'(1));
      chk("init_we_b", 32'(ram_we_b), 32'(1));
      chk("init_addr_a", 32'(ram_addr_a), 32'(2 * m_k));
      chk("init_addr_b", 32'(ram_addr_b), 32'(2 * m_k + 1));
      chk("init_data_a", 32'(ram_data_a), 32'(IVAL));
      chk("init_data_b", 32'(ram_data_b), 32'(IVAL));
      m_pa = 0; m_pb = 0;
      if (!rst) begin
        m_mem[2 * m_k]     = IVAL;
        m_mem[2 * m_k + 1] = IVAL;
        m_k++;
        if (m_k == HALF) m_done = 1;
      end
    end else begin
      conf  = req_a_valid && req_b_valid && (req_a_addr == req_b_addr) && (req_a_we || req_b_we);
      ra    = !conf || !m_prio;
      rb    = !conf || m_prio;
      acc_a = req_a_valid && ra;
      acc_b = req_b_valid && rb;
      chk("ready_a", 32'(req_a_ready), 32'(ra));
      chk("ready_b", 32'(req_b_ready), 32'(rb));
      chk("ram_we_a", 32'(ram_we_a), 32'(acc_a && req_a_we));
      chk("ram_we_b", 32'(ram_we_b), 32'(acc_b && req_b_we));
      if (acc_a) begin
        chk("ram_addr_a", 32'(ram_addr_a), 32'(req_a_addr));
        chk("ram_data_a", 32'(ram_data_a), 32'(req_a_wdata));
      end
      if (acc_b) begin
        chk("ram_addr_b", 32'(ram_addr_b), 32'(req_b_addr));
        chk("ram_data_b", 32'(ram_data_b), 32'(req_b_wdata));
      end
      // Reads see memory as it was before this cycle's writes.
      m_pa = acc_a && !req_a_we;
      m_pb = acc_b && !req_b_we;
      m_da = m_mem[req_a_addr];
      m_db = m_mem[req_b_addr];
      if (acc_a && req_a_we) m_mem[req_a_addr] = req_a_wdata;
      if (acc_b && req_b_we) m_mem[req_b_addr] = req_b_wdata;
      if (conf) begin
        m_prio = !m_prio;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_a_valid = v; req_a_we = we; req_a_addr = a; req_a_wdata = d;
  endtask

  task automatic set_b(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_b_valid = v; req_b_we = we; req_b_addr = a; req_b_wdata = d;
  endtask

  task automatic idle();
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
  endtask

  // Counts cycles from now until init_done rises; returns 0 if it never does.
  task automatic wait_init(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (init_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 3));
  endfunction

  initial begin
    int  cyc;
    bit  hold_a, hold_b;

    // Reset, then idle through the clear.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_init(cyc);
    chk("clear_cycles", 32'(cyc), 32'(HALF));
    $display("txn: initial clear took %0d cycles", cyc);

    // Sweep every address from both ports; the model expects all zeros.
    for (int a = 0; a < DEPTH; a++) begin
      set_a(1, 0, AW'(a), '0);
      set_b(1, 0, AW'(DEPTH - 1 - a), '0);
      step();
    end
    idle();
    chk("sweep_last_a_data", 32'(rsp_a_data), 32'(0));
    step();
    $display("txn: read sweep of %0d words on both ports", DEPTH);

    // Write then read-back on A.
    set_a(1, 1, 6'd5, 8'h3C); step();
    set_a(1, 0, 6'd5, 8'h00); step();
    idle();
    chk("wr_rd_rsp_a_valid", 32'(rsp_a_valid), 32'(1));
    chk("wr_rd_rsp_a_data", 32'(rsp_a_data), 32'(8'h3C));
    chk("wr_rd_rsp_b_valid", 32'(rsp_b_valid), 32'(0));
    step();
    $display("txn: A wrote 0x3C to 5 and read it back as %0h", rsp_a_data);

    // Write/write conflict on address 9: A wins first, B follows.
    set_a(1, 1, 6'd9, 8'h11);
    set_b(1, 1, 6'd9, 8'h22);
    #1;
    chk("conf1_ready_a", 32'(req_a_ready), 32'(1));
    chk("conf1_ready_b", 32'(req_b_ready), 32'(0));
    step();
    chk("conf1_cnt", 32'(conflict_cnt), 32'(1));
    set_a(0, 0, '0, '0);
    #1;
    chk("conf1_b_retry_ready", 32'(req_b_ready), 32'(1));
    step();
    idle();
    set_a(1, 0, 6'd9, 8'h00); step();
    idle();
    chk("conf1_final_data", 32'(rsp_a_data), 32'(8'h22));
    step();
    $display("txn: conflict on 9 resolved A then B, final %0h", rsp_a_data);

    // Three held conflicts: B is favoured now, so the winners go B, A, B.
    set_a(1, 1, 6'd12, 8'h33);
    set_b(1, 1, 6'd12, 8'h44);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("alt_ready_a", 32'(req_a_ready), 32'(i % 2));
      chk("alt_ready_b", 32'(req_b_ready), 32'((i + 1) % 2));
      step();
      chk("alt_cnt", 32'(conflict_cnt), 32'(2 + i));
      $display("txn: held conflict %0d, cnt %0d", i, conflict_cnt);
    end
    idle();
    step();

    // Same-address read/read is not a conflict.
    set_a(1, 1, 6'd7, 8'h5A); step();
    set_a(1, 0, 6'd7, 8'h00);
    set_b(1, 0, 6'd7, 8'h00);
    #1;
    chk("rr_ready_a", 32'(req_a_ready), 32'(1));
    chk("rr_ready_b", 32'(req_b_ready), 32'(1));
    step();
    idle();
    chk("rr_data_a", 32'(rsp_a_data), 32'(8'h5A));
    chk("rr_data_b", 32'(rsp_b_data), 32'(8'h5A));
    chk("rr_valid_b", 32'(rsp_b_valid), 32'(1));
    chk("rr_cnt", 32'(conflict_cnt), 32'(4));
    step();
    $display("txn: dual read of 7 returned %0h/%0h", rsp_a_data, rsp_b_data);

    // Randomized traffic. A stalled requester holds its request unchanged.
    hold_a = 0;
    hold_b = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold_a) set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
      if (!hold_b) set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
      #1;
      hold_a = req_a_valid && !req_a_ready;
      hold_b = req_b_valid && !req_b_ready;
      @(posedge clk);
      #1;
    end
    idle();
    step();
    $display("txn: random phase done, conflicts %0d", conflict_cnt);

    // Reset one cycle after a read is accepted. A read of word 0 is held
    // across the reset and the clear, and is served from the cleared RAM.
    set_a(1, 1, 6'd0, 8'hA5); step();
    set_a(1, 0, 6'd0, 8'h00); step();
    rst = 1'b1;
    #1;
    chk("rst_rsp_a_valid", 32'(rsp_a_valid), 32'(0));
    chk("rst_init_done", 32'(init_done), 32'(0));
    step();
    step();
    rst = 1'b0;
    wait_init(cyc);
    chk("clear2_cycles", 32'(cyc), 32'(HALF));
    step();
    idle();
    chk("word0_rsp_valid", 32'(rsp_a_valid), 32'(1));
    chk("word0_cleared", 32'(rsp_a_data), 32'(IVAL));
    step();
    $display("txn: reset after read, clear %0d cycles, word0 %0h", cyc, rsp_a_data);

    // Reset in the middle of the clear (k = 10).
    rst = 1'b1; step();
    rst = 1'b0;
    repeat (10) step();
    chk("midclear_addr_a", 32'(ram_addr_a), 32'(20));
    rst = 1'b1;
    #1;
    chk("midclear_addr_restart", 32'(ram_addr_a), 32'(0));
    chk("midclear_rsp_b_valid", 32'(rsp_b_valid), 32'(0));
    step();
    rst = 1'b0;
    wait_init(cyc);
    chk("clear3_cycles", 32'(cyc), 32'(HALF));
    set_b(1, 0, 6'd0, 8'h00); step();
    idle();
    chk("word0_after_midclear", 32'(rsp_b_data), 32'(IVAL));
    step();
    $display("txn: reset at k=10, clear restarted and took %0d cycles", cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
